// File: rtl/rv32i_types.sv
// Shared types and constants for the instruction-side line buffer.
//   imem_buf_state_t : controller states of imem_line_buffer
//   LINE_BYTES       : bytes held per line
//   BEAT_BITS        : width of one memory fill beat
//   line_word()      : extracts 32-bit word w from a little-endian line
package rv32i_types;

   localparam int LINE_BYTES = 32;
   localparam int BEAT_BITS  = 64;
   localparam int LINE_BITS  = LINE_BYTES * 8;
   localparam int TAG_BITS   = 27;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      FILL = 2'd2,
      RESP = 2'd3
   } imem_buf_state_t;

   // Word w sits at bits [32w+31:32w]; even words are the low half of a beat.
   function automatic logic [31:0] line_word(input logic [LINE_BITS-1:0] line,
                                             input logic [2:0]           w);
      return line[{w, 5'd0} +: 32];
   endfunction

endpackage

// File: rtl/imem_line_buffer.sv
// Single-line instruction fetch buffer. Holds one 32-byte line with its tag;
// hits answer on the next cycle, misses fetch the whole line from backing
// memory in BEATS 64-bit beats and then answer.
//   clk, rst_n            : clock, asynchronous active-low reset
//   imem_addr/imem_rmask  : fetch request (rmask != 0 means request)
//   imem_rdata/imem_resp  : registered instruction word and its one-cycle strobe
//   inval                 : drop the held line
//   bmem_addr/bmem_read   : line fill request, held until bmem_ready
//   bmem_rdata/bmem_rvalid: fill beats, in order, lowest bytes first
module imem_line_buffer
   import rv32i_types::*;
#(
   parameter int BEATS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] imem_addr,
   input  logic [3:0]  imem_rmask,
   output logic [31:0] imem_rdata,
   output logic        imem_resp,
   input  logic        inval,
   output logic [31:0] bmem_addr,
   output logic        bmem_read,
   input  logic        bmem_ready,
   input  logic [63:0] bmem_rdata,
   input  logic        bmem_rvalid
);

   localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

   imem_buf_state_t      state_r;
   imem_buf_state_t      state_s;
   logic [LINE_BITS-1:0] line_r;
   logic [TAG_BITS-1:0]  tag_r;
   logic [TAG_BITS-1:0]  req_tag_r;
   logic [2:0]           req_word_r;
   logic                 valid_r;
   logic                 inval_pend_r;
   logic [1:0]           beat_cnt_r;
   logic                 resp_r;
   logic [31:0]          rdata_r;
   logic                 read_r;
   logic [31:0]          baddr_r;
   logic                 req_s;
   logic                 hit_s;
   logic                 miss_s;
   logic                 last_beat_s;
   logic                 unused_s;

   assign imem_resp  = resp_r;
   assign imem_rdata = rdata_r;
   assign bmem_read  = read_r;
   assign bmem_addr  = baddr_r;

   // Byte offset within the word is irrelevant for word fetches.
   assign unused_s = ^imem_addr[1:0];

   // Request classification; a concurrent inval turns a would-be hit into a miss.
   always_comb begin
      req_s       = (imem_rmask != 4'd0);
      hit_s       = req_s && valid_r && !inval && (tag_r == imem_addr[31:5]);
      miss_s      = req_s && !hit_s;
      last_beat_s = bmem_rvalid && (beat_cnt_r == LAST_BEAT);
   end

   // Next-state logic of the fill controller.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (miss_s) state_s = REQ;
            else        state_s = IDLE;
         end
         REQ: begin
            if (bmem_ready) state_s = FILL;
            else            state_s = REQ;
         end
         FILL: begin
            if (last_beat_s) state_s = RESP;
            else             state_s = FILL;
         end
         RESP:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= IDLE;
      else        state_r <= state_s;
   end

   // Line storage, request latch and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_r       <= '0;
         tag_r        <= '0;
         req_tag_r    <= '0;
         req_word_r   <= 3'd0;
         valid_r      <= 1'b0;
         inval_pend_r <= 1'b0;
         beat_cnt_r   <= 2'd0;
         resp_r       <= 1'b0;
         rdata_r      <= 32'd0;
         read_r       <= 1'b0;
         baddr_r      <= 32'd0;
      end else begin
         resp_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (hit_s) begin
                  resp_r  <= 1'b1;
                  rdata_r <= line_word(line_r, imem_addr[4:2]);
               end else if (miss_s) begin
                  // The line is about to be overwritten, so it stops being valid now.
                  req_tag_r    <= imem_addr[31:5];
                  req_word_r   <= imem_addr[4:2];
                  read_r       <= 1'b1;
                  baddr_r      <= {imem_addr[31:5], 5'd0};
                  valid_r      <= 1'b0;
                  inval_pend_r <= 1'b0;
                  beat_cnt_r   <= 2'd0;
               end else if (inval) begin
                  valid_r <= 1'b0;
               end
            end
            REQ: begin
               if (bmem_ready) read_r <= 1'b0;
               if (inval) inval_pend_r <= 1'b1;
            end
            FILL: begin
               if (inval) inval_pend_r <= 1'b1;
               if (bmem_rvalid) begin
                  line_r[{beat_cnt_r, 6'd0} +: BEAT_BITS] <= bmem_rdata;
                  if (last_beat_s) begin
                     beat_cnt_r <= 2'd0;
                     tag_r      <= req_tag_r;
                     // An invalidate seen during the fill leaves the new line unusable.
                     valid_r    <= !(inval_pend_r || inval);
                  end else begin
                     beat_cnt_r <= beat_cnt_r + 2'd1;
                  end
               end
            end
            RESP: begin
               resp_r  <= 1'b1;
               rdata_r <= line_word(line_r, req_word_r);
               if (inval) valid_r <= 1'b0;
            end
            default: begin
               resp_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/imem_line_buffer.md
IMEM_LINE_BUFFER -- requirements
Module: imem_line_buffer

Interface
REQ-001 SHALL have parameter BEATS, default 4, meaning 64-bit beats per line fill (line = 32 bytes).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port imem_addr  input  32  fetch byte address; bits [1:0] ignored.
REQ-005 SHALL have port imem_rmask  input  4  nonzero = fetch request.
REQ-006 SHALL have port imem_rdata  output  32  fetched instruction word.
REQ-007 SHALL have port imem_resp  output  1  one-cycle pulse; imem_rdata valid.
REQ-008 SHALL have port inval  input  1  invalidate held line.
REQ-009 SHALL have port bmem_addr  output  32  line-aligned fill address.
REQ-010 SHALL have port bmem_read  output  1  fill request, held until accepted.
REQ-011 SHALL have port bmem_ready  input  1  memory accepts bmem_read this cycle.
REQ-012 SHALL have port bmem_rdata  input  64  fill beat data.
REQ-013 SHALL have port bmem_rvalid  input  1  bmem_rdata valid this cycle.

Function
REQ-014 SHALL hold one line: 256-bit data, 27-bit tag (addr[31:5]), valid bit.
REQ-015 SHALL use states IDLE, REQ, FILL, RESP.
REQ-016 IDLE, rmask!=0, valid and tag match (hit): SHALL drive imem_resp=1 next cycle with word addr[4:2]; state stays IDLE.
REQ-017 Back-to-back hits SHALL sustain one response per cycle; a request in a cycle with imem_resp=1 is evaluated like any IDLE request.
REQ-018 IDLE, rmask!=0, miss: SHALL latch addr, go REQ, drive bmem_read=1, bmem_addr={addr[31:5],5'b0} next cycle.
REQ-019 REQ: bmem_read and bmem_addr SHALL be held stable until bmem_ready=1; then go FILL, bmem_read=0 next cycle.
REQ-020 FILL: each bmem_rvalid beat k (0..BEATS-1, in order) SHALL write line bytes [8k+7:8k]; 2-bit beat counter, wrap at BEATS-1.
REQ-021 After last beat SHALL set tag, valid=1, go RESP; RESP SHALL drive imem_resp=1 with latched word for exactly one cycle, then IDLE.
REQ-022 Miss latency: request at cycle 0, bmem_ready at cycle 1 with zero wait, beats cycles 2..5 -> imem_resp at cycle 7.
REQ-023 Word w SHALL come from beat w>>1, upper half if w[0]=1 (little-endian).
REQ-024 imem_rmask=0 SHALL never produce imem_resp; rmask changes during REQ/FILL SHALL be ignored (latched address used).
REQ-025 bmem_rvalid outside FILL SHALL be ignored.
REQ-026 inval in IDLE SHALL clear valid next cycle; simultaneous with a hit request, the request SHALL be treated as miss.
REQ-027 inval during REQ/FILL/RESP SHALL let fill complete and response issue, but line SHALL end invalid.
REQ-028 imem_rdata SHALL be registered; value when imem_resp=0 is don't-care but SHALL not be X after reset.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, valid=0, beat counter=0, imem_resp=0, imem_rdata=0, bmem_read=0, bmem_addr=0.
REQ-030 Reset mid-fill SHALL abandon the fill without response; late beats after release are ignored per REQ-025.

Structure
REQ-031 State enum imem_buf_state_t and constants LINE_BYTES=32, BEAT_BITS=64 SHALL live in rv32i_types.
REQ-032 Block SHALL be flat; no sub-module.

Verification
REQ-033 Cold fetch addr 0x0000_1008, bmem_ready immediate, beats 0x11..,0x2222_2222_3333_3333 at beat1 -> bmem_addr 0x0000_1000, imem_resp cycle 7, rdata 0x3333_3333.
REQ-034 After REQ-033, fetches 0x1000,0x1004,...,0x101C on consecutive cycles -> 8 consecutive resp pulses, no bmem_read.
REQ-035 Fetch 0x0000_2000 after line 0x1000 valid, bmem_ready delayed 3 cycles -> bmem_read held 3 cycles, addr stable 0x2000, resp after 4th beat+2.
REQ-036 inval asserted during beat 2 of fill -> resp delivered; repeat fetch same addr re-issues bmem_read.
REQ-037 rst_n low during beat 1 -> outputs 0 at once; stray rvalid after release ignored; next fetch performs full fill.
REQ-038 rmask=0 with random addr for 20 cycles -> no imem_resp, no bmem_read.
